// File: rtl/ex_fwd_stage_pkg.sv
// ex_fwd_stage_pkg : opcodes and shared widths for the execute/forwarding stage.
// Revision 1.0
`default_nettype none

package ex_fwd_stage_pkg;

  localparam int REG_ADDR_W     = 3;
  localparam int DEFAULT_DATA_W = 8;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD   = 3'd0;
  localparam op_t OP_SUB   = 3'd1;
  localparam op_t OP_AND   = 3'd2;
  localparam op_t OP_OR    = 3'd3;
  localparam op_t OP_XOR   = 3'd4;
  localparam op_t OP_SLL   = 3'd5;
  localparam op_t OP_SRL   = 3'd6;
  localparam op_t OP_PASSB = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ex_fwd_stage_if.sv
// ex_fwd_stage_if : ID/EX inputs, comparator flags and EX/WB outputs of the execute stage.
// Revision 1.0 -- id_s1/id_s2 exist only when EX_ZERO_REG_EN is defined.
`default_nettype none

interface ex_fwd_stage_if
  import ex_fwd_stage_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 16
) ();

  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  op_t                   id_op;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_wen;
  logic [DATA_W-1:0]     id_a;
  logic [DATA_W-1:0]     id_b;
  logic                  fwdA;
  logic                  fwdB;
`ifdef EX_ZERO_REG_EN
  logic [REG_ADDR_W-1:0] id_s1;
  logic [REG_ADDR_W-1:0] id_s2;
`endif
  logic [REG_ADDR_W-1:0] prev_dst;
  logic                  ex_valid;
  logic                  ex_wen;
  logic [REG_ADDR_W-1:0] ex_dst;
  logic [DATA_W-1:0]     ex_result;
  logic                  ex_carry;
  logic                  ex_zero;
  logic [CNT_W-1:0]      retired;

  modport slave (
    input  stall, flush, id_valid, id_op, id_dst, id_wen, id_a, id_b, fwdA, fwdB,
`ifdef EX_ZERO_REG_EN
    input  id_s1, id_s2,
`endif
    output prev_dst, ex_valid, ex_wen, ex_dst, ex_result, ex_carry, ex_zero, retired
  );

  modport master (
    output stall, flush, id_valid, id_op, id_dst, id_wen, id_a, id_b, fwdA, fwdB,
`ifdef EX_ZERO_REG_EN
    output id_s1, id_s2,
`endif
    input  prev_dst, ex_valid, ex_wen, ex_dst, ex_result, ex_carry, ex_zero, retired
  );

endinterface

`default_nettype wire

// File: rtl/ex_fwd_stage_alu.sv
// ex_alu : combinational ALU; carry is bit DATA_W of the widened add/subtract.
// Revision 1.0
`default_nettype none

module ex_alu
  import ex_fwd_stage_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int SHAMT_W = 3
) (
  input  op_t               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum_w;
  logic [DATA_W:0] diff_w;

  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  // SUB carry is the not-borrow of A + ~B + 1
  assign diff_w = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD:   begin result_o = sum_w[DATA_W-1:0];  carry_o = sum_w[DATA_W];  end
      OP_SUB:   begin result_o = diff_w[DATA_W-1:0]; carry_o = diff_w[DATA_W]; end
      OP_AND:   result_o = a_i & b_i;
      OP_OR:    result_o = a_i | b_i;
      OP_XOR:   result_o = a_i ^ b_i;
      OP_SLL:   result_o = a_i << b_i[SHAMT_W-1:0];
      OP_SRL:   result_o = a_i >> b_i[SHAMT_W-1:0];
      default:  result_o = b_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_fwd_stage.sv
// ex_fwd_stage : operand forwarding, ALU and EX/WB register; EX_ZERO_REG_EN makes r0 hard-wired zero.
// Revision 1.0
`default_nettype none

module ex_fwd_stage
  import ex_fwd_stage_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int SHAMT_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  ex_fwd_stage_if.slave bus
);

  logic                  ex_valid_q;
  logic                  ex_wen_q;
  logic [REG_ADDR_W-1:0] ex_dst_q;
  logic [DATA_W-1:0]     ex_result_q;
  logic                  ex_carry_q;
  logic                  ex_zero_q;
  logic [CNT_W-1:0]      retired_q;

  logic                  fwd_ok;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     result_d;
  logic                  carry_d;
  logic                  wen_d;

  // The comparator matches on address only; a match counts only if the slot really wrote.
  assign fwd_ok = ex_valid_q & ex_wen_q;

  always_comb begin
    op_a  = (bus.fwdA & fwd_ok) ? ex_result_q : bus.id_a;
    op_b  = (bus.fwdB & fwd_ok) ? ex_result_q : bus.id_b;
    wen_d = bus.id_valid & bus.id_wen;
`ifdef EX_ZERO_REG_EN
    if (bus.id_s1 == '0) op_a = '0;
    if (bus.id_s2 == '0) op_b = '0;
    if (bus.id_dst == '0) wen_d = 1'b0;
`endif
  end

  ex_alu #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .op_i     (bus.id_op),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (result_d),
    .carry_o  (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_wen_q    <= 1'b0;
      ex_dst_q    <= '0;
      ex_result_q <= '0;
      ex_carry_q  <= 1'b0;
      ex_zero_q   <= 1'b0;
      retired_q   <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
      ex_wen_q   <= 1'b0;
    end else if (!bus.stall) begin
      ex_valid_q  <= bus.id_valid;
      ex_wen_q    <= wen_d;
      ex_dst_q    <= bus.id_dst;
      ex_result_q <= result_d;
      ex_carry_q  <= carry_d;
      ex_zero_q   <= (result_d == '0);
      if (bus.id_valid) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.prev_dst  = ex_dst_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_wen    = ex_wen_q;
  assign bus.ex_dst    = ex_dst_q;
  assign bus.ex_result = ex_result_q;
  assign bus.ex_carry  = ex_carry_q;
  assign bus.ex_zero   = ex_zero_q;
  assign bus.retired   = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_fwd_stage.sv
// tb_ex_fwd_stage : scoreboard bench for ex_fwd_stage; r0 scenario built only with EX_ZERO_REG_EN.
// Revision 1.0
`default_nettype none

module tb_ex_fwd_stage;

  typedef struct packed {
    logic        v;
    logic        w;
    logic [2:0]  p;
    logic [2:0]  d;
    logic [7:0]  r;
    logic        c;
    logic        z;
    logic [15:0] n;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  snap_t sb[$];
  snap_t exp_s;
  snap_t obs_s;

  logic        m_v = 1'b0, m_w = 1'b0, m_c = 1'b0, m_z = 1'b0;
  logic [2:0]  m_d = '0;
  logic [7:0]  m_r = '0;
  logic [15:0] m_n = '0;

  ex_fwd_stage_if #(.DATA_W(8), .CNT_W(16)) bus ();

  ex_fwd_stage #(.DATA_W(8), .SHAMT_W(3), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic snap_t observe();
    return '{bus.ex_valid, bus.ex_wen, bus.prev_dst, bus.ex_dst, bus.ex_result,
             bus.ex_carry, bus.ex_zero, bus.retired};
  endfunction

  // Drive one cycle, predict the EX/WB state it should produce, and queue the prediction.
  task automatic drive(input logic r, input logic fl, input logic st, input logic iv,
                       input logic [2:0] op, input logic [2:0] dst, input logic wen,
                       input logic [7:0] a, input logic [7:0] b, input logic fa, input logic fb,
                       input logic [2:0] s1, input logic [2:0] s2);
    logic [7:0] oa, ob, res;
    logic [8:0] wide;
    logic       cy, wq;
    rst = r; bus.flush = fl; bus.stall = st; bus.id_valid = iv; bus.id_op = op;
    bus.id_dst = dst; bus.id_wen = wen; bus.id_a = a; bus.id_b = b;
    bus.fwdA = fa; bus.fwdB = fb;
    oa = (fa && m_v && m_w) ? m_r : a;
    ob = (fb && m_v && m_w) ? m_r : b;
    wq = iv & wen;
`ifdef EX_ZERO_REG_EN
    bus.id_s1 = s1; bus.id_s2 = s2;
    if (s1 == 3'd0) oa = 8'h00;
    if (s2 == 3'd0) ob = 8'h00;
    if (dst == 3'd0) wq = 1'b0;
`else
    if (s1 === 3'bx || s2 === 3'bx) wq = 1'b0;
`endif
    cy = 1'b0;
    case (op)
      3'd0: begin wide = oa + ob; res = wide[7:0]; cy = wide[8]; end
      3'd1: begin wide = {1'b0, oa} - {1'b0, ob}; res = wide[7:0]; cy = (oa >= ob); end
      3'd2: res = oa & ob;
      3'd3: res = oa | ob;
      3'd4: res = oa ^ ob;
      3'd5: res = oa << ob[2:0];
      3'd6: res = oa >> ob[2:0];
      default: res = ob;
    endcase
    if (r) begin
      m_v = 0; m_w = 0; m_d = 0; m_r = 0; m_c = 0; m_z = 0; m_n = 0;
    end else if (fl) begin
      m_v = 0; m_w = 0;
    end else if (!st) begin
      m_v = iv; m_w = wq; m_d = dst; m_r = res; m_c = cy; m_z = (res == 8'h00);
      if (iv) m_n = m_n + 16'd1;
    end
    sb.push_back('{m_v, m_w, m_d, m_d, m_r, m_c, m_z, m_n});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 3'($urandom));
      exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
      if (obs_s !== exp_s || obs_s !== '0) begin
        n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, obs_s, snap_t'(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 1, 3'd0, 3'd1, 1, 8'h05, 8'h03, 0, 0, 3'd2, 3'd3);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_result !== 8'h08) begin
      n_fail++; $display("FAIL b2b_add: got %h expected %h", obs_s, exp_s);
    end
    drive(0, 0, 0, 1, 3'd1, 3'd2, 1, 8'h77, 8'h02, 1, 0, 3'd1, 3'd3);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_result !== 8'h06 || bus.ex_carry !== 1'b1 ||
        bus.retired !== 16'd2) begin
      n_fail++; $display("FAIL b2b_sub_fwd: got %h expected %h", obs_s, exp_s);
    end
    // id_dst equals its own source: only the prior result (6) is forwarded
    drive(0, 0, 0, 1, 3'd0, 3'd2, 1, 8'h55, 8'h01, 1, 0, 3'd2, 3'd3);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_result !== 8'h07) begin
      n_fail++; $display("FAIL self_fwd: got %h expected %h", obs_s, exp_s);
    end
  endtask

  task automatic test_unqualified();
    drive(0, 0, 0, 1, 3'd7, 3'd4, 0, 8'h00, 8'h40, 0, 0, 3'd1, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_wen !== 1'b0) begin
      n_fail++; $display("FAIL nowen_slot: got %h expected %h", obs_s, exp_s);
    end
    drive(0, 0, 0, 1, 3'd7, 3'd5, 1, 8'h00, 8'h11, 0, 1, 3'd1, 3'd4);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_result !== 8'h11) begin
      n_fail++; $display("FAIL unqual_fwd: got %h expected %h", obs_s, exp_s);
    end
    // invalid slot (id_valid low, id_wen high) must not forward either
    drive(0, 0, 0, 0, 3'd0, 3'd6, 1, 8'h20, 8'h00, 0, 0, 3'd1, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s) begin
      n_fail++; $display("FAIL invalid_slot: got %h expected %h", obs_s, exp_s);
    end
    drive(0, 0, 0, 1, 3'd0, 3'd1, 1, 8'h03, 8'h04, 1, 1, 3'd6, 3'd6);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_result !== 8'h07) begin
      n_fail++; $display("FAIL invalid_fwd: got %h expected %h", obs_s, exp_s);
    end
  endtask

  task automatic test_flush_stall();
    logic [15:0] n0;
    drive(0, 0, 0, 1, 3'd0, 3'd3, 1, 8'h01, 8'h01, 0, 0, 3'd1, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_result !== 8'h02) begin
      n_fail++; $display("FAIL fs_capture: got %h expected %h", obs_s, exp_s);
    end
    n0 = bus.retired;
    drive(0, 1, 1, 1, 3'd4, 3'd5, 1, 8'h0F, 8'hF0, 0, 0, 3'd1, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_valid !== 1'b0 || bus.ex_result !== 8'h02 ||
        bus.retired !== n0) begin
      n_fail++; $display("FAIL flush_stall: got %h expected %h", obs_s, exp_s);
    end
    drive(0, 0, 1, 1, 3'd3, 3'd6, 1, 8'hAA, 8'h55, 1, 1, 3'd1, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s) begin
      n_fail++; $display("FAIL stall_hold: got %h expected %h", obs_s, exp_s);
    end
  endtask

  task automatic test_arith_edges();
    logic [7:0] a_t[4] = '{8'hFF, 8'h81, 8'h80, 8'h03};
    logic [7:0] b_t[4] = '{8'h01, 8'h01, 8'h07, 8'h05};
    logic [2:0] o_t[4] = '{3'd0, 3'd5, 3'd6, 3'd1};
    logic [7:0] r_t[4] = '{8'h00, 8'h02, 8'h01, 8'hFE};
    logic [1:0] f_t[4] = '{2'b11, 2'b00, 2'b00, 2'b00};  // {carry, zero}
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, o_t[i], 3'd7, 1, a_t[i], b_t[i], 0, 0, 3'd1, 3'd2);
      exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
      if (obs_s !== exp_s || bus.ex_result !== r_t[i] ||
          {bus.ex_carry, bus.ex_zero} !== f_t[i]) begin
        n_fail++; $display("FAIL arith[%0d]: got %h expected %h", i, obs_s, exp_s);
      end
    end
  endtask

`ifdef EX_ZERO_REG_EN
  task automatic test_zero_reg();
    drive(0, 0, 0, 1, 3'd0, 3'd0, 1, 8'h05, 8'h03, 0, 0, 3'd1, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_wen !== 1'b0) begin
      n_fail++; $display("FAIL zr_wen: got %h expected %h", obs_s, exp_s);
    end
    drive(0, 0, 0, 1, 3'd0, 3'd3, 1, 8'h30, 8'h00, 0, 0, 3'd1, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s) begin
      n_fail++; $display("FAIL zr_setup: got %h expected %h", obs_s, exp_s);
    end
    drive(0, 0, 0, 1, 3'd0, 3'd4, 1, 8'h22, 8'h01, 1, 0, 3'd0, 3'd2);
    exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
    if (obs_s !== exp_s || bus.ex_result !== 8'h01) begin
      n_fail++; $display("FAIL zr_opa: got %h expected %h", obs_s, exp_s);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 3'($urandom),
            3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom), 3'($urandom));
      exp_s = sb.pop_front(); obs_s = observe(); n_checks++;
      if (obs_s !== exp_s) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs_s, exp_s);
      end
    end
  endtask

  initial begin
    bus.flush = 0; bus.stall = 0; bus.id_valid = 0; bus.id_op = '0; bus.id_dst = '0;
    bus.id_wen = 0; bus.id_a = '0; bus.id_b = '0; bus.fwdA = 0; bus.fwdB = 0;
`ifdef EX_ZERO_REG_EN
    bus.id_s1 = 3'd1; bus.id_s2 = 3'd2;
`endif
    #1;
    test_reset();
    test_back_to_back();
    test_unqualified();
    test_flush_stall();
    test_arith_edges();
`ifdef EX_ZERO_REG_EN
    test_zero_reg();
`endif
    test_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_fwd_stage.md
Name: ex_fwd_stage

Overview:
- Execute stage plus EX/WB pipeline register for the 4-stage, 8-register core; consumes the fwdA/fwdB match flags of the forwarding comparator and drives its prev_dst input.
- Selects operands (register-file value or previous-cycle result), performs the ALU operation, and registers result, destination and write-enable for writeback.
- Qualifies raw forwarding matches with the validity and write-enable of the previous instruction; the comparator matches on address only.

Parameters:
- DATA_W, 8, datapath width in bits.
- SHAMT_W, 3, shift-amount bits taken from operand B; must equal clog2(DATA_W).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all EX/WB state this cycle.
- flush  in  1  kill the instruction being captured this cycle.
- id_valid  in  1  ID/EX slot holds a real instruction.
- id_op  in  3  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 PASSB.
- id_dst  in  3  destination register.
- id_wen  in  1  instruction writes id_dst.
- id_a  in  DATA_W  register-file value of source 1.
- id_b  in  DATA_W  register-file value of source 2 or immediate.
- fwdA  in  1  comparator match, prev_dst == source 1.
- fwdB  in  1  comparator match, prev_dst == source 2.
- prev_dst  out  3  equals ex_dst; feeds the comparator.
- ex_valid  out  1  EX/WB slot valid.
- ex_wen  out  1  register-file write enable to writeback.
- ex_dst  out  3  registered destination.
- ex_result  out  DATA_W  registered ALU result.
- ex_carry  out  1  carry (ADD) or not-borrow (SUB); 0 for all other ops.
- ex_zero  out  1  ex_result == 0.
- retired  out  CNT_W  count of valid instructions captured.

Behaviour:
- Reset: synchronous, active-high. All outputs 0 on the first edge with rst high; rst overrides flush and stall.
- Priority each edge: rst > flush > stall > capture.
- Forward qualifier: fwd_ok = ex_valid & ex_wen.
- Operand A = (fwdA & fwd_ok) ? ex_result : id_a. Operand B = (fwdB & fwd_ok) ? ex_result : id_b. Selection is combinational, so forwarding adds zero latency.
- Capture (no rst, flush or stall):
  - ex_valid <= id_valid; ex_wen <= id_valid & id_wen; ex_dst <= id_dst.
  - ex_result <= ALU(A,B); ex_carry and ex_zero are updated to match.
  - retired increments by 1 when id_valid is high; wraps from 2^CNT_W-1 to 0.
- ALU:
  - ADD/SUB are modulo 2^DATA_W; the carry is bit DATA_W of the (DATA_W+1)-bit sum, or of A + ~B + 1 for SUB.
  - SLL/SRL are logical shifts by B[SHAMT_W-1:0].
  - PASSB outputs B.
- Flush: ex_valid and ex_wen <= 0. ex_dst, ex_result and the flags hold. retired does not increment. Flush with stall still flushes.
- Stall: every register holds, including retired. Writeback may repeat the same write, which is idempotent.
- A match against an invalid or non-writing previous slot must not forward. An instruction whose id_dst equals its own source forwards only the prior result.
- Latency: one cycle from ID/EX inputs to EX/WB outputs. Throughput: one instruction per cycle.

Optional Feature:
- Macro: EX_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired zero. An operand whose source-address match selects r0 reads as 0, and forwarding into it is suppressed.
  - ex_wen is forced to 0 when id_dst == 0.
  - The block needs the source addresses, so it gains inputs id_s1 and id_s2 (3 bits each).
- Undefined: r0 is an ordinary register; no extra ports.

Decomposition:
- Shared package holds:
  - opcode localparams OP_ADD..OP_PASSB;
  - REG_ADDR_W = 3;
  - the default DATA_W.
- One natural sub-module, ex_alu: combinational; takes op, a and b; returns result and carry.

Test Plan:
- Reset: rst high for 2 cycles with random inputs -> all outputs 0; retired = 0.
- Back-to-back forward:
  - Cycle 1: ADD r1 = 5 + 3, dst 1, wen 1.
  - Cycle 2: SUB with fwdA = 1, id_a = 0x77 (stale), id_b = 2.
  - Expected: ex_result = 8, then 6; ex_carry = 1 after SUB; retired = 2.
- Unqualified match: previous slot ex_wen = 0, ex_result = 0x40; fwdB = 1, id_b = 0x11, op PASSB -> ex_result = 0x11.
- Flush and stall:
  - Capture ADD 1 + 1 -> result 2.
  - flush + stall on the next edge -> ex_valid = 0, ex_result stays 2, retired unchanged.
  - stall alone on the following edge -> all outputs hold.
- Arithmetic edges, DATA_W = 8:
  - ADD 0xFF + 0x01 -> result 0x00, carry 1, zero 1.
  - SLL 0x81 by 1 -> 0x02.
  - SRL 0x80 by 7 -> 0x01.
- EX_ZERO_REG_EN: write dst 0 -> ex_wen = 0; a following op with id_s1 = 0, fwdA = 1 -> operand A = 0.
